// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: widths, FSM states,
// requester id and the ALU opcode map.
package alu_arb_pkg;

  localparam int N = 16;
  localparam int O = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

endpackage

// File: rtl/alu_arb_if.sv
// Request/response bundle between two requesters and the arbiter; the
// arbiter side is the slave modport.
interface alu_arb_if #(
  parameter int N = alu_arb_pkg::N,
  parameter int O = alu_arb_pkg::O
);

  logic         req_valid_0, req_valid_1;
  logic         req_ready_0, req_ready_1;
  logic [N-1:0] req_InA_0, req_InA_1;
  logic [N-1:0] req_InB_0, req_InB_1;
  logic [O-1:0] req_Op_0, req_Op_1;
  logic         req_Cin_0, req_Cin_1;
  logic         req_invA_0, req_invA_1;
  logic         req_invB_0, req_invB_1;
  logic         req_sign_0, req_sign_1;
  logic         rsp_valid_0, rsp_valid_1;
  logic         rsp_ready_0, rsp_ready_1;
  logic [N-1:0] rsp_Out;
  logic         rsp_Ofl, rsp_Zero;

  modport master (
    output req_valid_0, req_valid_1, req_InA_0, req_InA_1, req_InB_0, req_InB_1,
           req_Op_0, req_Op_1, req_Cin_0, req_Cin_1, req_invA_0, req_invA_1,
           req_invB_0, req_invB_1, req_sign_0, req_sign_1, rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_Out, rsp_Ofl, rsp_Zero
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_InA_0, req_InA_1, req_InB_0, req_InB_1,
           req_Op_0, req_Op_1, req_Cin_0, req_Cin_1, req_invA_0, req_invA_1,
           req_invB_0, req_invB_1, req_sign_0, req_sign_1, rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_Out, rsp_Ofl, rsp_Zero
  );

endinterface

// File: rtl/alu_arb_alu.sv
// Combinational ALU: optional operand inversion, add with carry-in, shifts,
// rotates and bitwise ops; Ofl is signed or unsigned overflow of ADD only.
module alu_arb_alu
  import alu_arb_pkg::*;
#(
  parameter int N = 16,
  parameter int O = 3
) (
  input  logic [N-1:0] InA_i,
  input  logic [N-1:0] InB_i,
  input  logic [O-1:0] Op_i,
  input  logic         Cin_i,
  input  logic         invA_i,
  input  logic         invB_i,
  input  logic         sign_i,
  output logic [N-1:0] Out_o,
  output logic         Ofl_o,
  output logic         Zero_o
);

  localparam int SW = $clog2(N);

  logic [N-1:0]   a, b;
  logic [N:0]     sumW;
  logic [SW-1:0]  sh;
  logic [2*N-1:0] rolW, rorW;

  assign a    = invA_i ? ~InA_i : InA_i;
  assign b    = invB_i ? ~InB_i : InB_i;
  assign sh   = b[SW-1:0];
  assign sumW = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, Cin_i};
  // Rotates shift a doubled copy so the wrapped bits land in the kept half.
  assign rolW = {a, a} << sh;
  assign rorW = {a, a} >> sh;

  always_comb begin
    Out_o = '0;
    Ofl_o = 1'b0;
    case (Op_i)
      OP_ROL: Out_o = rolW[2*N-1:N];
      OP_SLL: Out_o = a << sh;
      OP_ROR: Out_o = rorW[N-1:0];
      OP_SRL: Out_o = a >> sh;
      OP_ADD: begin
        Out_o = sumW[N-1:0];
        Ofl_o = sign_i ? ((a[N-1] == b[N-1]) && (sumW[N-1] != a[N-1])) : sumW[N];
      end
      OP_AND: Out_o = a & b;
      OP_OR:  Out_o = a | b;
      OP_XOR: Out_o = a ^ b;
      default: Out_o = '0;
    endcase
  end

  assign Zero_o = (Out_o == '0);

endmodule

// File: rtl/alu_arb.sv
// Two-requester front end that time-shares one ALU: accept in IDLE, compute
// from registered operands in EXEC, hold the registered result in RESP.
module alu_arb #(
  parameter int N = alu_arb_pkg::N,
  parameter int O = alu_arb_pkg::O
) (
  input  logic       clk,
  input  logic       rst,
  alu_arb_if.slave   bus
);

  import alu_arb_pkg::*;

  state_t       state_q, state_d;
  req_id_t      prio_q, prio_d, id_q, grant;
  logic [N-1:0] inA_q, inB_q, res_q;
  logic [O-1:0] op_q;
  logic         cin_q, invA_q, invB_q, sign_q, ofl_q, zero_q;
  logic [N-1:0] aluOut;
  logic         aluOfl, aluZero;
  logic         accept;

  // The pointer only breaks ties; a lone requester is always granted.
  always_comb begin
    grant = prio_q;
    if (bus.req_valid_0 && !bus.req_valid_1)      grant = 1'b0;
    else if (!bus.req_valid_0 && bus.req_valid_1) grant = 1'b1;
  end

  assign accept = (state_q == IDLE) &&
                  ((bus.req_valid_0 && grant == 1'b0) || (bus.req_valid_1 && grant == 1'b1));

  always_comb begin
    state_d         = state_q;
    prio_d          = prio_q;
    bus.req_ready_0 = 1'b0;
    bus.req_ready_1 = 1'b0;
    bus.rsp_valid_0 = 1'b0;
    bus.rsp_valid_1 = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready_0 = !rst && bus.req_valid_0 && (grant == 1'b0);
        bus.req_ready_1 = !rst && bus.req_valid_1 && (grant == 1'b1);
        if (accept) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        bus.rsp_valid_0 = !rst && (id_q == 1'b0);
        bus.rsp_valid_1 = !rst && (id_q == 1'b1);
        if ((id_q == 1'b0) ? bus.rsp_ready_0 : bus.rsp_ready_1) begin
          state_d = IDLE;
          prio_d  = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      inA_q   <= '0;
      inB_q   <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      invA_q  <= 1'b0;
      invB_q  <= 1'b0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      ofl_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (accept) begin
        id_q   <= grant;
        inA_q  <= grant ? bus.req_InA_1  : bus.req_InA_0;
        inB_q  <= grant ? bus.req_InB_1  : bus.req_InB_0;
        op_q   <= grant ? bus.req_Op_1   : bus.req_Op_0;
        cin_q  <= grant ? bus.req_Cin_1  : bus.req_Cin_0;
        invA_q <= grant ? bus.req_invA_1 : bus.req_invA_0;
        invB_q <= grant ? bus.req_invB_1 : bus.req_invB_0;
        sign_q <= grant ? bus.req_sign_1 : bus.req_sign_0;
      end
      if (state_q == EXEC) begin
        res_q  <= aluOut;
        ofl_q  <= aluOfl;
        zero_q <= aluZero;
      end
    end
  end

  alu_arb_alu #(.N(N), .O(O)) u_alu (
    .InA_i  (inA_q),
    .InB_i  (inB_q),
    .Op_i   (op_q),
    .Cin_i  (cin_q),
    .invA_i (invA_q),
    .invB_i (invB_q),
    .sign_i (sign_q),
    .Out_o  (aluOut),
    .Ofl_o  (aluOfl),
    .Zero_o (aluZero)
  );

  assign bus.rsp_Out  = res_q;
  assign bus.rsp_Ofl  = ofl_q;
  assign bus.rsp_Zero = zero_q;

endmodule
